// File: rtl/opcode_fetch_pkg.sv
// Shared definitions for the instruction-byte fetch / prefix-collapse stage.
// Prefix byte values, fetch FSM encodings and the decoded bundle layout.
package opcode_fetch_pkg;

    localparam logic [7:0] PREFIX_PAGE2 = 8'h10;
    localparam logic [7:0] PREFIX_PAGE3 = 8'h11;

    localparam logic [1:0] ST_FETCH_OP   = 2'd0;
    localparam logic [1:0] ST_FETCH_POST = 2'd1;
    localparam logic [1:0] ST_HOLD       = 2'd2;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  postbyte0;
        logic        page2;
        logic        page3;
        logic        illegal;
        logic [15:0] op_pc;
    } op_bundle_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PREFIX_PAGE2) || (b == PREFIX_PAGE3);
    endfunction

endpackage

// File: rtl/opcode_fetch_if.sv
// Byte-bus and decoded-bundle signals between the fetch stage (master) and
// the memory / sequencer side (slave).
interface opcode_fetch_if;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic [7:0]  opcode;
    logic [7:0]  postbyte0;
    logic        page2_valid;
    logic        page3_valid;
    logic        op_illegal;
    logic [15:0] op_pc;
    logic        op_valid;
    logic        op_ready;

    modport master (
        output mem_req, mem_addr,
        input  mem_rdata, mem_ack,
        output opcode, postbyte0, page2_valid, page3_valid, op_illegal, op_pc, op_valid,
        input  op_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_rdata, mem_ack,
        input  opcode, postbyte0, page2_valid, page3_valid, op_illegal, op_pc, op_valid,
        output op_ready
    );

endinterface

// File: rtl/opcode_fetch.sv
// Fetches instruction bytes at pc, folds 0x10/0x11 page prefixes into page
// flags and holds the resulting bundle until the sequencer accepts it.
module opcode_fetch
    import opcode_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          MAX_PREFIX = 4
) (
    input  logic         cpu_clk,
    input  logic         cpu_reset,
    input  logic         fetch_en,
    input  logic         pc_load,
    input  logic [15:0]  pc_new,
    output logic [15:0]  pc,
    opcode_fetch_if.master bus
);

    localparam int            CW        = $clog2(MAX_PREFIX + 1);
    localparam logic [CW-1:0] PFX_LIMIT = CW'(MAX_PREFIX - 1);

    logic [1:0]    state;
    logic          mem_req_q;
    logic [15:0]   pc_q;
    logic [CW-1:0] pfx_cnt;
    logic          pg3_latch;
    logic          op_valid_q;
    op_bundle_t    bnd;

    logic          ack;
    logic          rd_pfx;
    logic          rd_pg3;

    // An ack only counts against a request we actually issued.
    assign ack    = mem_req_q & bus.mem_ack;
    assign rd_pfx = is_prefix(bus.mem_rdata);
    assign rd_pg3 = (bus.mem_rdata == PREFIX_PAGE3);

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state      <= ST_FETCH_OP;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            pfx_cnt    <= '0;
            pg3_latch  <= 1'b0;
            op_valid_q <= 1'b0;
            bnd        <= '0;
        end else if (pc_load) begin
            // Redirect wins over everything, including a same-cycle ack.
            state       <= ST_FETCH_OP;
            pc_q        <= pc_new;
            mem_req_q   <= 1'b0;
            pfx_cnt     <= '0;
            pg3_latch   <= 1'b0;
            op_valid_q  <= 1'b0;
            bnd.page2   <= 1'b0;
            bnd.page3   <= 1'b0;
            bnd.illegal <= 1'b0;
        end else begin
            case (state)
                ST_FETCH_OP: begin
                    if (ack) begin
                        bnd.opcode  <= bus.mem_rdata;
                        bnd.op_pc   <= pc_q;
                        bnd.page2   <= 1'b0;
                        bnd.page3   <= 1'b0;
                        bnd.illegal <= 1'b0;
                        pc_q        <= pc_q + 16'd1;
                        if (rd_pfx) begin
                            pfx_cnt   <= CW'(1);
                            pg3_latch <= rd_pg3;
                            mem_req_q <= 1'b1;
                            state     <= ST_FETCH_POST;
                        end else begin
                            bnd.postbyte0 <= 8'h00;
                            mem_req_q     <= 1'b0;
                            op_valid_q    <= 1'b1;
                            state         <= ST_HOLD;
                        end
                    end else if (!mem_req_q) begin
                        // fetch_en only matters between requests.
                        mem_req_q <= fetch_en;
                    end
                end
                ST_FETCH_POST: begin
                    mem_req_q <= 1'b1;
                    if (ack) begin
                        pc_q <= pc_q + 16'd1;
                        if (rd_pfx && (pfx_cnt < PFX_LIMIT)) begin
                            pfx_cnt   <= pfx_cnt + CW'(1);
                            pg3_latch <= rd_pg3;
                        end else begin
                            // A prefix at the chain limit is reported, not paged.
                            bnd.postbyte0 <= bus.mem_rdata;
                            bnd.illegal   <= rd_pfx;
                            bnd.page2     <= !rd_pfx && !pg3_latch;
                            bnd.page3     <= !rd_pfx &&  pg3_latch;
                            mem_req_q     <= 1'b0;
                            op_valid_q    <= 1'b1;
                            state         <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (op_valid_q && bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        pfx_cnt    <= '0;
                        state      <= ST_FETCH_OP;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state     <= ST_FETCH_OP;
                end
            endcase
        end
    end

    assign pc              = pc_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = pc_q;
    assign bus.opcode      = bnd.opcode;
    assign bus.postbyte0   = bnd.postbyte0;
    assign bus.page2_valid = bnd.page2;
    assign bus.page3_valid = bnd.page3;
    assign bus.op_illegal  = bnd.illegal;
    assign bus.op_pc       = bnd.op_pc;
    assign bus.op_valid    = op_valid_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Directed and randomized bench for opcode_fetch: a byte-array memory with
// configurable wait states and an instruction-level model of prefix folding.
module tb_opcode_fetch;

    localparam logic [15:0] RPC  = 16'h1000;
    localparam int          MAXP = 4;

    logic        cpu_clk   = 1'b0;
    logic        cpu_reset = 1'b1;
    logic        fetch_en  = 1'b0;
    logic        pc_load   = 1'b0;
    logic [15:0] pc_new    = '0;
    logic [15:0] pc;

    opcode_fetch_if bus();

    opcode_fetch #(.RESET_PC(RPC), .MAX_PREFIX(MAXP)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_reset(cpu_reset),
        .fetch_en (fetch_en),
        .pc_load  (pc_load),
        .pc_new   (pc_new),
        .pc       (pc),
        .bus      (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [7:0]  opc;
        logic [7:0]  pb;
        logic        p2;
        logic        p3;
        logic        ill;
        logic [15:0] at;
        logic [15:0] nxt;
    } exp_t;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          cyc_n = 0;
    int          ack_cyc = -100;
    int          hs_cnt = 0;
    bit          prev_req = 0, prev_ack = 0, prev_ld = 0, prev_valid = 0;
    logic [15:0] prev_addr = '0, prev_ld_addr = '0, exp_pc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic bit is_pfx(input logic [7:0] b);
        return (b == 8'h10) || (b == 8'h11);
    endfunction

    // Instruction starting at a: walk bytes, last prefix picks the page,
    // the MAXP-th consecutive prefix makes it illegal.
    function automatic exp_t predict(input logic [15:0] a);
        exp_t       e;
        logic [7:0] b;
        logic [7:0] last;
        int         n;
        e.at = a; e.opc = mem[a]; e.pb = 8'h00; e.p2 = 0; e.p3 = 0; e.ill = 0;
        a = a + 16'd1;
        if (is_pfx(e.opc)) begin
            last = e.opc;
            n = 1;
            for (int k = 0; k < MAXP; k++) begin
                b = mem[a];
                a = a + 16'd1;
                if (!is_pfx(b)) begin
                    e.pb = b; e.p2 = (last == 8'h10); e.p3 = (last == 8'h11);
                    break;
                end
                n++;
                if (n == MAXP) begin
                    e.pb = b; e.ill = 1;
                    break;
                end
                last = b;
            end
        end
        e.nxt = a;
        return e;
    endfunction

    // Sample outputs on the falling edge and check bus/handshake invariants.
    task automatic obs();
        @(negedge cpu_clk);
        cyc_n++;
        if (prev_req && !prev_ack && !prev_ld && !cpu_reset) begin
            chk("req_hold", 32'(bus.mem_req), 1);
            chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
        end
        if (prev_ld && !cpu_reset) begin
            chk("ld_req_drop", 32'(bus.mem_req), 0);
            chk("ld_valid_clr", 32'(bus.op_valid), 0);
            chk("ld_pc", 32'(pc), 32'(prev_ld_addr));
        end
        if (bus.mem_req) chk("addr_is_pc", 32'(bus.mem_addr), 32'(pc));
        if (bus.op_valid) begin
            chk("pages_excl", 32'(bus.page2_valid & bus.page3_valid), 0);
            chk("hold_noreq", 32'(bus.mem_req), 0);
            if (!prev_valid) chk("latency", 32'(cyc_n - ack_cyc), 1);
        end
    endtask

    // Drive memory response, consumer ready and optional redirect for one cycle.
    task automatic drv(input bit rdy, input bit ld, input logic [15:0] ld_addr);
        bit   a;
        exp_t e;
        a = 1'b0;
        if (cpu_reset) wcnt = 0;
        if (bus.mem_req && !cpu_reset) begin
            if (wait_cfg < 0) a = ($urandom_range(0, 2) == 0);
            else              a = (wcnt >= wait_cfg);
            if (a) wcnt = 0; else wcnt++;
        end
        if (rdy && bus.op_valid && !ld && !cpu_reset) begin
            e = predict(exp_pc);
            chk("hs_opcode", 32'(bus.opcode), 32'(e.opc));
            chk("hs_op_pc", 32'(bus.op_pc), 32'(e.at));
            chk("hs_postbyte0", 32'(bus.postbyte0), 32'(e.pb));
            chk("hs_illegal", 32'(bus.op_illegal), 32'(e.ill));
            chk("hs_pc", 32'(pc), 32'(e.nxt));
            if (!e.ill) begin
                chk("hs_page2", 32'(bus.page2_valid), 32'(e.p2));
                chk("hs_page3", 32'(bus.page3_valid), 32'(e.p3));
            end
            exp_pc = e.nxt;
            hs_cnt++;
        end
        if (a && !ld) ack_cyc = cyc_n;
        if (ld) begin
            exp_pc = ld_addr;
            wcnt = 0;
        end
        bus.mem_ack   = a;
        bus.mem_rdata = a ? mem[bus.mem_addr] : 8'($urandom);
        bus.op_ready  = rdy;
        pc_load       = ld;
        pc_new        = ld ? ld_addr : 16'h0000;
        prev_req      = bus.mem_req;
        prev_ack      = a;
        prev_ld       = ld;
        prev_ld_addr  = ld_addr;
        prev_addr     = bus.mem_addr;
        prev_valid    = bus.op_valid;
    endtask

    // Returns right after an obs() that saw op_valid; caller must drv() next.
    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            obs();
            if (bus.op_valid) return;
            drv(0, 0, 16'h0000);
        end
        obs();
        chk("wait_valid", 32'(bus.op_valid), 1);
    endtask

    initial begin
        bit   found;
        int   base;
        bit   ld;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.op_ready = 1'b0;

        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'h11 : 8'h10)
                                                 : 8'($urandom);
        mem[16'h1000] = 8'h86;
        mem[16'h2000] = 8'h10; mem[16'h2001] = 8'h8E;
        mem[16'h2100] = 8'h10; mem[16'h2101] = 8'h11; mem[16'h2102] = 8'h10; mem[16'h2103] = 8'h11;
        mem[16'h2200] = 8'h10; mem[16'h2201] = 8'h11; mem[16'h2202] = 8'h83;
        mem[16'h2300] = 8'h10; mem[16'h2301] = 8'h8E;
        mem[16'h3000] = 8'h4F;
        mem[16'h4000] = 8'h10; mem[16'h4001] = 8'h11; mem[16'h4002] = 8'h20;
        mem[16'hFFFF] = 8'h10; mem[16'h0000] = 8'h8E;

        // Reset values
        cpu_reset = 1'b1; fetch_en = 1'b1; exp_pc = RPC; wait_cfg = 0;
        obs(); drv(0, 0, 16'h0000); obs();
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_pc", 32'(pc), 'h1000);
        chk("rst_op_valid", 32'(bus.op_valid), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        chk("rst_postbyte0", 32'(bus.postbyte0), 0);
        chk("rst_op_pc", 32'(bus.op_pc), 0);
        chk("rst_page2", 32'(bus.page2_valid), 0);
        chk("rst_page3", 32'(bus.page3_valid), 0);
        chk("rst_illegal", 32'(bus.op_illegal), 0);
        cpu_reset = 1'b0;
        drv(0, 0, 16'h0000);

        // Unpaged 0x86 at RESET_PC, zero-wait ack, held until op_ready
        obs();
        chk("t1_req", 32'(bus.mem_req), 1);
        chk("t1_addr", 32'(bus.mem_addr), 'h1000);
        drv(0, 0, 16'h0000);
        obs();
        chk("t1_valid", 32'(bus.op_valid), 1);
        chk("t1_opcode", 32'(bus.opcode), 'h86);
        chk("t1_postbyte0", 32'(bus.postbyte0), 0);
        chk("t1_page2", 32'(bus.page2_valid), 0);
        chk("t1_page3", 32'(bus.page3_valid), 0);
        chk("t1_op_pc", 32'(bus.op_pc), 'h1000);
        chk("t1_pc", 32'(pc), 'h1001);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 16'h0000); obs();
            chk("t1_hold_valid", 32'(bus.op_valid), 1);
            chk("t1_hold_opcode", 32'(bus.opcode), 'h86);
        end
        drv(1, 0, 16'h0000); obs();
        chk("t1_accepted", 32'(bus.op_valid), 0);
        chk("t1_bubble", 32'(bus.mem_req), 0);
        drv(0, 0, 16'h0000); obs();
        chk("t1_refetch", 32'(bus.mem_req), 1);
        chk("t1_refetch_addr", 32'(bus.mem_addr), 'h1001);

        // Page 2: 10 8E at 2000
        drv(0, 1, 16'h2000);
        wait_valid(20);
        chk("t2_opcode", 32'(bus.opcode), 'h10);
        chk("t2_postbyte0", 32'(bus.postbyte0), 'h8E);
        chk("t2_page2", 32'(bus.page2_valid), 1);
        chk("t2_page3", 32'(bus.page3_valid), 0);
        chk("t2_pc", 32'(pc), 'h2002);
        chk("t2_op_pc", 32'(bus.op_pc), 'h2000);
        drv(1, 0, 16'h0000);

        // Prefix chain hits the limit
        obs(); drv(0, 1, 16'h2100);
        wait_valid(20);
        chk("t3_illegal", 32'(bus.op_illegal), 1);
        chk("t3_postbyte0", 32'(bus.postbyte0), 'h11);
        chk("t3_opcode", 32'(bus.opcode), 'h10);
        drv(1, 0, 16'h0000);

        // Last prefix wins: 10 11 83 is page 3
        obs(); drv(0, 1, 16'h2200);
        wait_valid(20);
        chk("t4_page3", 32'(bus.page3_valid), 1);
        chk("t4_page2", 32'(bus.page2_valid), 0);
        chk("t4_postbyte0", 32'(bus.postbyte0), 'h83);
        chk("t4_illegal", 32'(bus.op_illegal), 0);
        drv(1, 0, 16'h0000);

        // pc_load coincident with the postbyte ack
        obs(); drv(0, 1, 16'h2300);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            obs();
            if (bus.mem_req && bus.mem_addr == 16'h2301) found = 1;
            else drv(0, 0, 16'h0000);
        end
        chk("t5_reach_post", 32'(found), 1);
        drv(0, 1, 16'h3000);
        obs();
        chk("t5_valid", 32'(bus.op_valid), 0);
        chk("t5_pc", 32'(pc), 'h3000);
        drv(0, 0, 16'h0000); obs();
        chk("t5_req", 32'(bus.mem_req), 1);
        chk("t5_addr", 32'(bus.mem_addr), 'h3000);
        drv(0, 0, 16'h0000);
        wait_valid(20);
        chk("t5_opcode", 32'(bus.opcode), 'h4F);
        drv(1, 0, 16'h0000);

        // 3-cycle wait states, consumer stalls for 5 cycles
        wait_cfg = 3;
        obs(); drv(0, 1, 16'h4000);
        wait_valid(60);
        chk("t6_page3", 32'(bus.page3_valid), 1);
        chk("t6_postbyte0", 32'(bus.postbyte0), 'h20);
        chk("t6_op_pc", 32'(bus.op_pc), 'h4000);
        chk("t6_pc", 32'(pc), 'h4003);
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 16'h0000); obs();
            chk("t6_stall_valid", 32'(bus.op_valid), 1);
            chk("t6_stall_opcode", 32'(bus.opcode), 'h10);
            chk("t6_stall_postbyte0", 32'(bus.postbyte0), 'h20);
            chk("t6_stall_page3", 32'(bus.page3_valid), 1);
        end
        drv(1, 0, 16'h0000);

        // Prefix at FFFF, postbyte at 0000
        wait_cfg = 0;
        obs(); drv(0, 1, 16'hFFFF);
        wait_valid(20);
        chk("t7_op_pc", 32'(bus.op_pc), 'hFFFF);
        chk("t7_opcode", 32'(bus.opcode), 'h10);
        chk("t7_postbyte0", 32'(bus.postbyte0), 'h8E);
        chk("t7_page2", 32'(bus.page2_valid), 1);
        chk("t7_illegal", 32'(bus.op_illegal), 0);
        chk("t7_pc", 32'(pc), 'h0001);
        drv(1, 0, 16'h0000);

        // Reset in the middle of a waiting request
        wait_cfg = 3;
        obs(); drv(0, 1, 16'h2000);
        obs(); drv(0, 0, 16'h0000);
        obs();
        chk("t8_pending", 32'(bus.mem_req), 1);
        cpu_reset = 1'b1;
        drv(0, 0, 16'h0000); obs();
        chk("t8_rst_req", 32'(bus.mem_req), 0);
        chk("t8_rst_pc", 32'(pc), 'h1000);
        chk("t8_rst_valid", 32'(bus.op_valid), 0);
        cpu_reset = 1'b0;
        exp_pc = RPC;
        drv(0, 0, 16'h0000);

        // Random memory, wait states, stalls, fetch_en gaps and redirects
        wait_cfg = -1;
        base = hs_cnt;
        for (int c = 0; c < 4000; c++) begin
            obs();
            fetch_en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 79) == 0);
            drv(1'($urandom_range(0, 1)), ld, 16'($urandom));
        end
        chk("rand_progress", 32'((hs_cnt - base) > 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
